// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared states, init nibble/config byte tables and clear/home codes for the LCD sequencer
package lcd_seq_pkg;
   typedef enum logic [2:0] {PWRUP, INIT_NIB, INIT_CFG, IDLE, XFER_HI, XFER_LO, WAIT} state_t;
   typedef enum logic [1:0] {SP_IDLE, SP_SETUP, SP_HIGH, SP_HOLD} strobe_t;
   localparam logic [3:0][3:0] INIT_NIBS = {4'h2, 4'h3, 4'h3, 4'h3};
   localparam logic [3:0][7:0] CFG_BYTES = {8'h06, 8'h01, 8'h0C, 8'h28};
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME = 8'h02;
   function automatic int unsigned cmax(input int unsigned a, input int unsigned b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/lcd_nibble_strobe.sv
// lcd_nibble_strobe: one setup cycle, EPW_CYC cycles of e high, one hold cycle; done marks the hold cycle
module lcd_nibble_strobe #(
   parameter int unsigned EPW_CYC = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] nibble,
   input  logic       rs,
   output logic [3:0] lcd_db,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       done
);
   import lcd_seq_pkg::*;
   localparam int EW = $clog2(EPW_CYC + 1);
   strobe_t phase, phase_d;
   logic [EW-1:0] cnt, cnt_d;
   logic [3:0] db_d;
   logic rs_d;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= SP_IDLE;
         cnt <= '0;
         lcd_db <= '0;
         lcd_rs <= 1'b0;
      end else begin
         phase <= phase_d;
         cnt <= cnt_d;
         lcd_db <= db_d;
         lcd_rs <= rs_d;
      end
   end
   // a start during the hold cycle chains straight into the next setup cycle
   always_comb begin
      phase_d = phase;
      cnt_d = cnt;
      db_d = lcd_db;
      rs_d = lcd_rs;
      if (start) begin
         phase_d = SP_SETUP;
         db_d = nibble;
         rs_d = rs;
      end else if (phase == SP_SETUP) begin
         phase_d = SP_HIGH;
         cnt_d = EW'(EPW_CYC - 1);
      end else if (phase == SP_HIGH) begin
         phase_d = cnt == '0 ? SP_HOLD : SP_HIGH;
         cnt_d = cnt - 1'b1;
      end else if (phase == SP_HOLD) begin
         phase_d = SP_IDLE;
      end
   end
   assign lcd_e = phase == SP_HIGH;
   assign done = phase == SP_HOLD;
endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780 4-bit init and byte writer; LCD_SEQ_XFER_COUNT_EN adds the xfer_count output
module lcd_sequencer #(
   parameter int unsigned PWRUP_CYC = 1875000,
   parameter int unsigned INIT_CYC  = 512500,
   parameter int unsigned EPW_CYC   = 32,
   parameter int unsigned CMD_CYC   = 5000,
   parameter int unsigned CLR_CYC   = 205000
) (
   input  logic        sys0_clk,
   input  logic        sys0_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rs,
   input  logic [7:0]  req_data,
   output logic [3:0]  lcd_db,
   output logic        lcd_e,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        init_done,
`ifdef LCD_SEQ_XFER_COUNT_EN
   output logic        busy,
   output logic [15:0] xfer_count
`else
   output logic        busy
`endif
);
   import lcd_seq_pkg::*;
   localparam int unsigned MAXC = cmax(cmax(PWRUP_CYC, INIT_CYC), cmax(CMD_CYC, CLR_CYC));
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] PW_L = CW'(PWRUP_CYC - 1);
   localparam logic [CW-1:0] IN_L = CW'(INIT_CYC - 1);
   localparam logic [CW-1:0] CM_L = CW'(CMD_CYC - 1);
   localparam logic [CW-1:0] CL_L = CW'(CLR_CYC - 1);
   state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [1:0] idx, idx_d;
   logic nib_wait, nib_wait_d;
   logic [7:0] byte_q, byte_d;
   logic rs_q, rs_d;
   logic st_start, st_rs, st_done, is_clr;
   logic [3:0] st_nib;
   lcd_nibble_strobe #(.EPW_CYC(EPW_CYC)) u_strobe (
      .clk(sys0_clk),
      .rst(sys0_rst),
      .start(st_start),
      .nibble(st_nib),
      .rs(st_rs),
      .lcd_db(lcd_db),
      .lcd_e(lcd_e),
      .lcd_rs(lcd_rs),
      .done(st_done)
   );
   always_ff @(posedge sys0_clk or posedge sys0_rst) begin
      if (sys0_rst) begin
         state <= PWRUP;
         cnt <= PW_L;
         idx <= '0;
         nib_wait <= 1'b0;
         byte_q <= '0;
         rs_q <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
         idx <= idx_d;
         nib_wait <= nib_wait_d;
         byte_q <= byte_d;
         rs_q <= rs_d;
         init_done <= init_done | (state_d == IDLE);
      end
   end
   assign is_clr = !rs_q && (byte_q == CMD_CLEAR || byte_q == CMD_HOME);
   // config bytes reuse the XFER/WAIT path; init_done tells WAIT whether to return to INIT_CFG
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      idx_d = idx;
      nib_wait_d = nib_wait;
      byte_d = byte_q;
      rs_d = rs_q;
      st_start = 1'b0;
      st_nib = byte_q[7:4];
      st_rs = rs_q;
      case (state)
         PWRUP: begin
            if (cnt == '0) begin
               st_start = 1'b1;
               st_nib = INIT_NIBS[0];
               st_rs = 1'b0;
               idx_d = '0;
               nib_wait_d = 1'b0;
               state_d = INIT_NIB;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         INIT_NIB: begin
            if (!nib_wait) begin
               if (st_done) begin
                  nib_wait_d = 1'b1;
                  cnt_d = IN_L;
               end
            end else if (cnt != '0) begin
               cnt_d = cnt - 1'b1;
            end else if (idx == 2'd3) begin
               idx_d = '0;
               state_d = INIT_CFG;
            end else begin
               idx_d = idx + 2'd1;
               st_start = 1'b1;
               st_nib = INIT_NIBS[idx_d];
               st_rs = 1'b0;
               nib_wait_d = 1'b0;
            end
         end
         INIT_CFG: begin
            st_start = 1'b1;
            st_nib = CFG_BYTES[idx][7:4];
            st_rs = 1'b0;
            byte_d = CFG_BYTES[idx];
            rs_d = 1'b0;
            state_d = XFER_HI;
         end
         IDLE: begin
            if (req_valid && req_ready) begin
               st_start = 1'b1;
               st_nib = req_data[7:4];
               st_rs = req_rs;
               byte_d = req_data;
               rs_d = req_rs;
               state_d = XFER_HI;
            end
         end
         XFER_HI: begin
            if (st_done) begin
               st_start = 1'b1;
               st_nib = byte_q[3:0];
               state_d = XFER_LO;
            end
         end
         XFER_LO: begin
            if (st_done) begin
               cnt_d = is_clr ? CL_L : CM_L;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_d = cnt - 1'b1;
            end else if (init_done || idx == 2'd3) begin
               state_d = IDLE;
            end else begin
               idx_d = idx + 2'd1;
               state_d = INIT_CFG;
            end
         end
         default: state_d = PWRUP;
      endcase
   end
   assign req_ready = state == IDLE && init_done;
   assign busy = state != IDLE;
   assign lcd_rw = 1'b0;
`ifdef LCD_SEQ_XFER_COUNT_EN
   always_ff @(posedge sys0_clk or posedge sys0_rst) begin
      if (sys0_rst) xfer_count <= '0;
      else if (req_valid && req_ready) xfer_count <= xfer_count + 16'd1;
   end
`endif
endmodule
